spmv_row_mac: RTL and testbench
===============================

SPMV_ROW_MAC -- requirements
Module: spmv_row_mac

Interface
REQ-001 SHALL have parameter VEC_W, default 32, width of matrix and vector values (signed two's complement).
REQ-002 SHALL have parameter ACC_W, default 64, accumulator and result width (signed, ACC_W >= 2*VEC_W).
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port spmv_init  input  1  synchronous job clear.
REQ-006 SHALL have port prefetch_done  input  1  dense vector fully loaded in the vector file.
REQ-007 SHALL have port num_rows  input  16  rows this channel processes; sampled in IDLE.
REQ-008 SHALL have ports in_val input 1, in_rdy output 1: element stream handshake.
REQ-009 SHALL have ports in_col_idx input 16, in_mat_val input VEC_W, in_row_end input 1 (last element of row), in_row_empty input 1 (beat carries no element).
REQ-010 SHALL have port col_idx_out  output  16  vector file lookup index, equal to in_col_idx combinationally.
REQ-011 SHALL have port col_val_in  input  VEC_W  vector file value for col_idx_out, valid in the same cycle.
REQ-012 SHALL have ports out_val output 1, out_rdy input 1, out_row_idx output 16, out_sum output ACC_W, out_ovf output 1.
REQ-013 SHALL have port done  output  1  all num_rows results handed off.

Function
REQ-014 SHALL implement FSM IDLE, RUN, DONE; IDLE->RUN when prefetch_done=1 and num_rows!=0; IDLE->DONE when prefetch_done=1 and num_rows==0; RUN->DONE on the out handshake of row num_rows-1; DONE held until spmv_init or reset.
REQ-015 SHALL accept an element on in_val&&in_rdy; in_rdy=1 only in RUN and when the pipeline is not stalled.
REQ-016 SHALL register in E1 the signed product in_mat_val*col_val_in (2*VEC_W bits, sign-extended to ACC_W), forced to 0 when in_row_empty=1, together with row_end.
REQ-017 SHALL in E2 add the E1 product to the accumulator; if E1 row_end=1, load acc+product into the output register, set out_val, and clear acc to 0 in the same edge.
REQ-018 SHALL assert out_val two clock edges after the edge accepting a row_end beat (accept edge, then E2 edge).
REQ-019 SHALL stall (in_rdy=0, E1 held) while E1 holds a row_end and out_val=1 and out_rdy=0; the simultaneous out handshake and E1 row_end load SHALL not stall.
REQ-020 SHALL hold out_row_idx, out_sum, out_ovf stable while out_val=1 and out_rdy=0; out_row_idx starts at 0 and increments by 1 per out handshake.
REQ-021 SHALL treat in_row_empty=1 with in_row_end=1 as a complete row producing out_sum=0.
REQ-022 SHALL assert done=1 only in DONE; in DONE in_rdy=0.
REQ-023 SHALL on spmv_init=1 return to IDLE, clear E1, acc, out_val, out_row_idx, out_ovf, discarding any partial row or pending result; spmv_init has priority over all other events.

Reset
REQ-024 SHALL on rst_n=0 at a clock edge set state=IDLE, in_rdy=0, out_val=0, out_row_idx=0, out_sum=0, out_ovf=0, done=0, acc=0, E1 valid=0.
REQ-025 SHALL apply reset mid-row or mid-handshake identically to REQ-024, with no result emitted.

Configuration
REQ-026 SHALL, when SPMV_MAC_SAT_EN is defined, saturate the accumulate (and the final load) to the signed ACC_W max/min and set a per-row sticky overflow presented on out_ovf with that row's result, cleared when acc clears.
REQ-027 SHALL, when SPMV_MAC_SAT_EN is not defined, wrap two's-complement modulo 2^ACC_W and tie out_ovf to 0.

Verification
REQ-028 SHALL cover: num_rows=1, beats (col 3, val 2, col_val 5),(col 7, val -4, col_val 3, row_end) -> out_sum=-2, out_row_idx=0, out_val 2 edges after second accept, then done=1.
REQ-029 SHALL cover: num_rows=3, middle row single beat in_row_empty=1,row_end=1 -> sums {x,0,y}, out_row_idx 0,1,2.
REQ-030 SHALL cover: out_rdy held 0 for 10 cycles with two back-to-back row_end beats -> in_rdy drops, second result not lost, outputs stable until released.
REQ-031 SHALL cover: spmv_init asserted mid-row with out_val=1 -> next cycle out_val=0, state IDLE, next job starts at out_row_idx=0 with acc=0.
REQ-032 SHALL cover: ACC_W=64, VEC_W=32, accumulate 3 products of (2^31-1)^2 -> with SPMV_MAC_SAT_EN out_sum=2^63-1, out_ovf=1; without it wrapped value, out_ovf=0.
REQ-033 SHALL cover: num_rows=0 with prefetch_done=1 -> done=1 next edge, in_rdy never asserted.

Source files
------------

// File: rtl/spmv_row_mac.sv
// -----------------------------------------------------------------------------
// spmv_row_mac -- one row-reduction channel of a sparse matrix-vector multiply.
//
// A stream of non-zero matrix elements (CSR order, one row after another) is
// multiplied by the matching dense-vector entry and summed per row. Each row
// result is handed off on a valid/ready output port with its row index.
//
// Pipeline:
//   accept edge : the element is multiplied by the vector value and the
//                 product lands in E1 (together with its row_end flag).
//   E2 edge     : the E1 product is added to the running accumulator. On a
//                 row_end the final sum is loaded into the output register
//                 and the accumulator clears in the same edge.
//
// Configuration:
//   SPMV_MAC_SAT_EN  defined     : accumulation saturates to the signed ACC_W
//                                  range; a per-row sticky flag is presented
//                                  on out_ovf alongside that row's result.
//                    not defined : accumulation wraps modulo 2^ACC_W and
//                                  out_ovf is tied to 0.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   spmv_init         synchronous job clear (highest priority after reset)
//   prefetch_done     dense vector fully loaded; starts a job from IDLE
//   num_rows          rows to process, sampled in IDLE
//   in_val / in_rdy   element stream handshake
//   in_col_idx        column of the element
//   in_mat_val        matrix value (signed)
//   in_row_end        element is the last of its row
//   in_row_empty      beat carries no element (contributes 0)
//   col_idx_out       vector-file lookup index (= in_col_idx)
//   col_val_in        vector-file value for col_idx_out, same cycle
//   out_val / out_rdy result handshake
//   out_row_idx       index of the presented row result
//   out_sum           row result (signed, ACC_W bits)
//   out_ovf           row overflowed (saturating build only)
//   done              all num_rows results handed off
// -----------------------------------------------------------------------------
module spmv_row_mac #(
   parameter int VEC_W = 32,
   parameter int ACC_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             spmv_init,
   input  logic             prefetch_done,
   input  logic [15:0]      num_rows,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [15:0]      in_col_idx,
   input  logic [VEC_W-1:0] in_mat_val,
   input  logic             in_row_end,
   input  logic             in_row_empty,
   output logic [15:0]      col_idx_out,
   input  logic [VEC_W-1:0] col_val_in,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [15:0]      out_row_idx,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                  state;
   logic [15:0]             rows_q;

   // E1 stage: registered product and its row_end marker
   logic                    e1_vld;
   logic                    e1_end;
   logic signed [ACC_W-1:0] e1_prod;

   // E2 stage: running row accumulator
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_next;

   logic signed [2*VEC_W-1:0] prod_full;
   logic signed [ACC_W-1:0]   prod_ext;

   logic stall;
   logic accept;
   logic out_hs;
   logic e2_fire;
   logic e2_load;
   logic last_row_hs;

   // The vector file is looked up with the incoming column directly so its
   // value arrives in the same cycle as the element it multiplies.
   assign col_idx_out = in_col_idx;

   // Full-precision signed product, then sign-extended to accumulator width.
   assign prod_full = (2*VEC_W)'($signed(in_mat_val)) * (2*VEC_W)'($signed(col_val_in));
   assign prod_ext  = ACC_W'(prod_full);

   // A row_end waiting in E1 can only be retired into the output register if
   // the register is empty or is being drained in this very cycle.
   assign stall       = e1_vld & e1_end & out_val & ~out_rdy;
   assign in_rdy      = (state == S_RUN) & ~stall;
   assign accept      = in_val & in_rdy;
   assign out_hs      = out_val & out_rdy;
   assign e2_fire     = e1_vld & ~stall;
   assign e2_load     = e2_fire & e1_end;
   assign last_row_hs = out_hs & (out_row_idx == rows_q - 16'd1);

`ifdef SPMV_MAC_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [ACC_W:0] sum_wide;
   logic                  add_ovf;
   logic                  acc_ovf;   // sticky overflow of the row in progress
   logic                  ovf_q;     // overflow flag of the presented result

   // One guard bit: the two top bits disagree exactly when the signed add
   // left the ACC_W range, and the guard bit gives the direction.
   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      sum_wide = (ACC_W+1)'(acc) + (ACC_W+1)'(e1_prod);
      add_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
      acc_next = sum_wide[ACC_W-1:0];
      if (add_ovf) begin
         acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end

   assign out_ovf = ovf_q;
`else
   // Plain two's-complement wrap.
   assign acc_next = acc + e1_prod;
   assign out_ovf  = 1'b0;
`endif

   // NOTE: all state below uses non-blocking assignments; rst_n is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         rows_q      <= '0;
         done        <= 1'b0;
         e1_vld      <= 1'b0;
         e1_end      <= 1'b0;
         e1_prod     <= '0;
         acc         <= '0;
         out_val     <= 1'b0;
         out_row_idx <= '0;
         out_sum     <= '0;
`ifdef SPMV_MAC_SAT_EN
         acc_ovf     <= 1'b0;
         ovf_q       <= 1'b0;
`endif
      end else if (spmv_init) begin
         // Job clear: drop any partial row and any result still on offer.
         state       <= S_IDLE;
         done        <= 1'b0;
         e1_vld      <= 1'b0;
         e1_end      <= 1'b0;
         e1_prod     <= '0;
         acc         <= '0;
         out_val     <= 1'b0;
         out_row_idx <= '0;
`ifdef SPMV_MAC_SAT_EN
         acc_ovf     <= 1'b0;
         ovf_q       <= 1'b0;
`endif
      end else begin
         // ---------------- control FSM ----------------
         case (state)
            S_IDLE: begin
               if (prefetch_done) begin
                  rows_q <= num_rows;
                  if (num_rows == 16'd0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (last_row_hs) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               // Held until spmv_init or reset.
            end
            default: begin
               state <= S_IDLE;
               done  <= 1'b0;
            end
         endcase

         // ---------------- E1: product register ----------------
         // Held unchanged while stalled so the pending row_end is not lost.
         if (!stall) begin
            e1_vld  <= accept;
            e1_end  <= accept & in_row_end;
            e1_prod <= (accept && !in_row_empty) ? prod_ext : '0;
         end

         // ---------------- E2: accumulate / retire ----------------
         if (e2_fire) begin
            if (e1_end) begin
               out_sum <= acc_next;
               acc     <= '0;
            end else begin
               acc     <= acc_next;
            end
         end

`ifdef SPMV_MAC_SAT_EN
         if (e2_fire) begin
            if (e1_end) begin
               ovf_q   <= acc_ovf | add_ovf;
               acc_ovf <= 1'b0;
            end else begin
               acc_ovf <= acc_ovf | add_ovf;
            end
         end
`endif

         // ---------------- output handshake ----------------
         // A load in the same cycle as a handshake replaces the drained
         // result, so out_val stays high for the next row.
         if (e2_load) begin
            out_val <= 1'b1;
         end else if (out_hs) begin
            out_val <= 1'b0;
         end

         if (out_hs) begin
            out_row_idx <= out_row_idx + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_spmv_row_mac.sv
// -----------------------------------------------------------------------------
// tb_spmv_row_mac -- self-checking bench for spmv_row_mac.
//
// A row-sum model kept in this bench computes every row result from the
// accepted elements with wide plain arithmetic and queues it; a monitor on
// the falling edge compares every presented result (index, sum, overflow)
// against the head of that queue. Directed tests add literal expectations
// for sums, latency, stall behaviour, job clear, empty jobs, overflow and
// reset. SPMV_MAC_SAT_EN selects the saturating expectations.
// -----------------------------------------------------------------------------
module tb_spmv_row_mac;

   localparam int VEC_W = 32;
   localparam int ACC_W = 64;

`ifdef SPMV_MAC_SAT_EN
   localparam logic signed [127:0] SAT_MAX = (128'sd1 <<< (ACC_W-1)) - 128'sd1;
   localparam logic signed [127:0] SAT_MIN = -(128'sd1 <<< (ACC_W-1));
`endif

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    spmv_init;
   logic                    prefetch_done;
   logic [15:0]             num_rows;
   logic                    in_val;
   logic                    in_rdy;
   logic [15:0]             in_col_idx;
   logic signed [VEC_W-1:0] in_mat_val;
   logic                    in_row_end;
   logic                    in_row_empty;
   logic [15:0]             col_idx_out;
   logic signed [VEC_W-1:0] col_val_in;
   logic                    out_val;
   logic                    out_rdy;
   logic [15:0]             out_row_idx;
   logic signed [ACC_W-1:0] out_sum;
   logic                    out_ovf;
   logic                    done;

   spmv_row_mac #(.VEC_W(VEC_W), .ACC_W(ACC_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .spmv_init     (spmv_init),
      .prefetch_done (prefetch_done),
      .num_rows      (num_rows),
      .in_val        (in_val),
      .in_rdy        (in_rdy),
      .in_col_idx    (in_col_idx),
      .in_mat_val    (in_mat_val),
      .in_row_end    (in_row_end),
      .in_row_empty  (in_row_empty),
      .col_idx_out   (col_idx_out),
      .col_val_in    (col_val_in),
      .out_val       (out_val),
      .out_rdy       (out_rdy),
      .out_row_idx   (out_row_idx),
      .out_sum       (out_sum),
      .out_ovf       (out_ovf),
      .done          (done)
   );

   always #5 clk = ~clk;

   // Small dense-vector file, answered combinationally.
   logic signed [VEC_W-1:0] vfile [16];
   assign col_val_in = vfile[col_idx_out[3:0]];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic signed [127:0] act,
                        input logic signed [127:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
      end
   endtask

   task automatic timeout_fail(input string name, input int cycles);
      n_tests++;
      n_fail++;
      $display("FAIL %s: no progress after %0d cycles", name, cycles);
   endtask

   // ---------------------------------------------------------------- model
   typedef struct {
      logic signed [ACC_W-1:0] sum;
      logic                    ovf;
   } res_t;

   typedef struct {
      int                      row;
      logic signed [ACC_W-1:0] sum;
      logic                    ovf;
   } got_t;

   res_t                exp_q[$];
   got_t                got_q[$];
   logic signed [127:0] m_acc = '0;
   logic                m_ovf = 1'b0;
   int                  m_row = 0;

   function automatic void model_beat(input logic signed [VEC_W-1:0] a,
                                      input logic signed [VEC_W-1:0] b,
                                      input logic last, input logic empty);
      longint              p;
      logic signed [127:0] s;
      p = empty ? 64'sd0 : longint'(a) * longint'(b);
      s = m_acc + 128'(p);
`ifdef SPMV_MAC_SAT_EN
      if (s > SAT_MAX) begin
         s     = SAT_MAX;
         m_ovf = 1'b1;
      end else if (s < SAT_MIN) begin
         s     = SAT_MIN;
         m_ovf = 1'b1;
      end
`else
      s = 128'($signed(s[ACC_W-1:0]));
`endif
      if (last) begin
         exp_q.push_back('{sum: s[ACC_W-1:0], ovf: m_ovf});
         m_acc = '0;
         m_ovf = 1'b0;
      end else begin
         m_acc = s;
      end
   endfunction

   // Monitor: sample away from the active edge; what is seen here is what
   // the next rising edge acts on.
   always @(negedge clk) begin
      if (!rst_n || spmv_init) begin
         exp_q.delete();
         m_acc = '0;
         m_ovf = 1'b0;
         m_row = 0;
      end else begin
         if (out_val) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_result: out_val=1 row %0d sum %0d, required no result",
                        out_row_idx, out_sum);
            end else begin
               check("mon_row_idx", out_row_idx, m_row);
               check("mon_sum", out_sum, exp_q[0].sum);
               check("mon_ovf", out_ovf, exp_q[0].ovf);
            end
            if (out_rdy) begin
               got_q.push_back('{row: int'(out_row_idx), sum: out_sum, ovf: out_ovf});
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               m_row++;
            end
         end
         if (in_val && in_rdy) begin
            model_beat(in_mat_val, vfile[in_col_idx[3:0]], in_row_end, in_row_empty);
         end
         if (done) check("mon_in_rdy_in_done", in_rdy, 0);
      end
   end

   // -------------------------------------------------------------- drivers
   task automatic send_beat(input logic [15:0] col, input logic signed [VEC_W-1:0] val,
                            input logic last, input logic empty);
      int cyc = 0;
      in_val       = 1'b1;
      in_col_idx   = col;
      in_mat_val   = val;
      in_row_end   = last;
      in_row_empty = empty;
      @(negedge clk);
      while (!in_rdy && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (!in_rdy) timeout_fail("accept_timeout", cyc);
      @(posedge clk); #1;
      in_val       = 1'b0;
      in_row_end   = 1'b0;
      in_row_empty = 1'b0;
   endtask

   task automatic start_job(input logic [15:0] n);
      @(posedge clk); #1;
      spmv_init     = 1'b1;
      prefetch_done = 1'b0;
      num_rows      = n;
      @(posedge clk); #1;
      spmv_init     = 1'b0;
      prefetch_done = 1'b1;
      @(posedge clk); #1;
      got_q.delete();
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      while (done !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      if (done !== 1'b1) timeout_fail({name, "_done_timeout"}, cyc);
      @(posedge clk); #1;
      check({name, "_no_pending"}, exp_q.size(), 0);
   endtask

   // ---------------------------------------------------------------- tests
   initial begin
      rst_n         = 1'b0;
      spmv_init     = 1'b0;
      prefetch_done = 1'b0;
      num_rows      = '0;
      in_val        = 1'b0;
      in_col_idx    = '0;
      in_mat_val    = '0;
      in_row_end    = 1'b0;
      in_row_empty  = 1'b0;
      out_rdy       = 1'b1;
      for (int i = 0; i < 16; i++) vfile[i] = '0;
      vfile[0] = 32'sh7FFF_FFFF;
      vfile[1] = 10;
      vfile[2] = -3;
      vfile[3] = 5;
      vfile[4] = 4;
      vfile[6] = 6;
      vfile[7] = 3;

      // Reset state
      @(negedge clk);
      check("rst_out_val", out_val, 0);
      check("rst_in_rdy", in_rdy, 0);
      check("rst_done", done, 0);
      check("rst_row_idx", out_row_idx, 0);
      check("rst_sum", out_sum, 0);
      check("rst_ovf", out_ovf, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Combinational vector-file index
      in_col_idx = 16'h1234;
      #1;
      check("col_idx_passthru", col_idx_out, 16'h1234);

      // T1: one row, two beats -> 2*5 + (-4)*3 = -2, latency, done
      start_job(16'd1);
      send_beat(16'd3, 2, 1'b0, 1'b0);
      send_beat(16'd7, -4, 1'b1, 1'b0);
      @(negedge clk);
      check("t1_out_val_after_1_edge", out_val, 0);
      @(negedge clk);
      check("t1_out_val_after_2_edges", out_val, 1);
      check("t1_sum", out_sum, -2);
      check("t1_row_idx", out_row_idx, 0);
      @(negedge clk);
      check("t1_done", done, 1);
      check("t1_out_val_drained", out_val, 0);
      wait_done("t1");
      check("t1_count", got_q.size(), 1);

      // T2: three rows, middle one empty -> {12, 0, -37}
      start_job(16'd3);
      send_beat(16'd4, 3, 1'b1, 1'b0);
      send_beat(16'd0, 99, 1'b1, 1'b1);
      send_beat(16'd6, -7, 1'b0, 1'b0);
      send_beat(16'd3, 1, 1'b1, 1'b0);
      wait_done("t2");
      check("t2_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         check("t2_sum0", got_q[0].sum, 12);
         check("t2_sum1", got_q[1].sum, 0);
         check("t2_sum2", got_q[2].sum, -37);
         check("t2_idx0", got_q[0].row, 0);
         check("t2_idx1", got_q[1].row, 1);
         check("t2_idx2", got_q[2].row, 2);
      end

      // T3: out_rdy low for 10+ cycles, back-to-back row_end beats
      start_job(16'd3);
      out_rdy = 1'b0;
      fork
         begin
            send_beat(16'd1, 2, 1'b1, 1'b0);
            send_beat(16'd2, 5, 1'b1, 1'b0);
            send_beat(16'd1, -1, 1'b1, 1'b0);
         end
         begin
            repeat (4) @(negedge clk);
            check("t3_in_rdy_stalled", in_rdy, 0);
            check("t3_out_val_held", out_val, 1);
            check("t3_sum_held", out_sum, 20);
            check("t3_idx_held", out_row_idx, 0);
            repeat (7) @(negedge clk);
            check("t3_in_rdy_still_stalled", in_rdy, 0);
            check("t3_sum_still_held", out_sum, 20);
            @(posedge clk); #1;
            out_rdy = 1'b1;
         end
      join
      wait_done("t3");
      check("t3_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         check("t3_sum0", got_q[0].sum, 20);
         check("t3_sum1", got_q[1].sum, -15);
         check("t3_sum2", got_q[2].sum, -10);
         check("t3_idx2", got_q[2].row, 2);
      end

      // T4: spmv_init mid-row with a result on offer
      start_job(16'd3);
      out_rdy = 1'b0;
      send_beat(16'd1, 1, 1'b1, 1'b0);
      send_beat(16'd2, 4, 1'b0, 1'b0);
      @(negedge clk);
      check("t4_out_val_before_init", out_val, 1);
      @(posedge clk); #1;
      spmv_init     = 1'b1;
      prefetch_done = 1'b0;
      @(posedge clk); #1;
      spmv_init = 1'b0;
      @(negedge clk);
      check("t4_out_val_cleared", out_val, 0);
      check("t4_idle_in_rdy", in_rdy, 0);
      check("t4_idle_done", done, 0);
      check("t4_row_idx_cleared", out_row_idx, 0);
      @(posedge clk); #1;
      out_rdy       = 1'b1;
      num_rows      = 16'd1;
      prefetch_done = 1'b1;
      got_q.delete();
      send_beat(16'd1, 3, 1'b1, 1'b0);
      wait_done("t4");
      check("t4_count", got_q.size(), 1);
      if (got_q.size() == 1) begin
         check("t4_sum_fresh_acc", got_q[0].sum, 30);
         check("t4_idx_restart", got_q[0].row, 0);
      end

      // T5: empty job (num_rows = 0); in_rdy must never rise
      @(posedge clk); #1;
      spmv_init     = 1'b1;
      prefetch_done = 1'b0;
      num_rows      = 16'd0;
      @(posedge clk); #1;
      spmv_init     = 1'b0;
      prefetch_done = 1'b1;
      in_val        = 1'b1;
      in_row_end    = 1'b1;
      @(negedge clk);
      check("t5_done_before_edge", done, 0);
      check("t5_in_rdy_idle", in_rdy, 0);
      @(negedge clk);
      check("t5_done_next_edge", done, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t5_in_rdy_never", in_rdy, 0);
         check("t5_done_held", done, 1);
      end
      @(posedge clk); #1;
      in_val     = 1'b0;
      in_row_end = 1'b0;
      check("t5_no_pending", exp_q.size(), 0);

      // T6: three products of (2^31-1)^2 overflow the 64-bit accumulator
      start_job(16'd1);
      send_beat(16'd0, 32'sh7FFF_FFFF, 1'b0, 1'b0);
      send_beat(16'd0, 32'sh7FFF_FFFF, 1'b0, 1'b0);
      send_beat(16'd0, 32'sh7FFF_FFFF, 1'b1, 1'b0);
      wait_done("t6");
      check("t6_count", got_q.size(), 1);
      if (got_q.size() == 1) begin
`ifdef SPMV_MAC_SAT_EN
         check("t6_sum_sat", got_q[0].sum, $signed(64'h7FFF_FFFF_FFFF_FFFF));
         check("t6_ovf_sat", got_q[0].ovf, 1);
`else
         check("t6_sum_wrap", got_q[0].sum, $signed(64'hBFFF_FFFD_0000_0003));
         check("t6_ovf_wrap", got_q[0].ovf, 0);
`endif
      end

      // T7: reset mid-row with a result on offer, then a fresh job
      start_job(16'd2);
      out_rdy = 1'b0;
      send_beat(16'd1, 1, 1'b1, 1'b0);
      send_beat(16'd4, 2, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("t7_rst_out_val", out_val, 0);
      check("t7_rst_sum", out_sum, 0);
      check("t7_rst_row_idx", out_row_idx, 0);
      check("t7_rst_done", done, 0);
      check("t7_rst_in_rdy", in_rdy, 0);
      @(posedge clk); #1;
      rst_n   = 1'b1;
      out_rdy = 1'b1;
      got_q.delete();
      send_beat(16'd2, 1, 1'b1, 1'b0);
      send_beat(16'd5, 7, 1'b1, 1'b1);
      wait_done("t7");
      check("t7_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("t7_sum0", got_q[0].sum, -3);
         check("t7_sum1", got_q[1].sum, 0);
         check("t7_idx0", got_q[0].row, 0);
         check("t7_idx1", got_q[1].row, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
